dec_scan_nto2n: RTL and testbench

//  Parametrised, registered N-to-2^N one-hot decoder with enable and a second, self-timed scan mode.

---
 rtl/dec_scan_nto2n.sv | 110 +++++++++++
 tb/tb_dec_scan_nto2n.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dec_scan_nto2n.sv
// ============================================================================
// dec_scan_nto2n : registered N-to-2^N one-hot decoder with direct/scan modes.
// Optional macro DEC_SCAN_WRAP_EN builds the scan wrap pulse on `wrap`.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dec_scan_nto2n #(
  parameter int IN_W     = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [IN_W-1:0]     in,
  output logic [2**IN_W-1:0]  out,
  output logic [IN_W-1:0]     idx,
  output logic                valid,
  output logic                wrap
);

  localparam int OUT_W = 2**IN_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            r_state;
  logic [OUT_W-1:0]  r_out;
  logic [IN_W-1:0]   r_idx;
  logic              r_valid;
  logic [DIV_W-1:0]  r_div_cnt;

  logic              w_scan_hold;
  logic              w_scan_step;
  logic [IN_W-1:0]   w_idx_next;

  assign w_scan_hold = en && mode && (r_state == SCAN);
  assign w_scan_step = w_scan_hold && (r_div_cnt == C_DIV_LAST);
  // Index width is exactly log2(OUT_W), so the increment wraps modulo OUT_W.
  assign w_idx_next  = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_div_cnt <= '0;
    end else if (!en) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_div_cnt <= '0;
    end else if (!mode) begin
      r_state   <= DIRECT;
      r_out     <= OUT_W'(1) << in;
      r_idx     <= in;
      r_valid   <= 1'b1;
      r_div_cnt <= '0;
    end else if (r_state != SCAN) begin
      // Scan entry always restarts the sweep at bit 0.
      r_state   <= SCAN;
      r_out     <= OUT_W'(1);
      r_idx     <= '0;
      r_valid   <= 1'b1;
      r_div_cnt <= '0;
    end else if (w_scan_step) begin
      r_state   <= SCAN;
      r_out     <= OUT_W'(1) << w_idx_next;
      r_idx     <= w_idx_next;
      r_valid   <= 1'b1;
      r_div_cnt <= '0;
    end else begin
      r_state   <= SCAN;
      r_valid   <= 1'b1;
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign out   = r_out;
  assign idx   = r_idx;
  assign valid = r_valid;

`ifdef DEC_SCAN_WRAP_EN
  logic r_wrap;

  // Pulses alongside the edge that moves out from the top line back to bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_scan_step && (&r_idx);
    end
  end

  assign wrap = r_wrap;
`else
  assign wrap = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dec_scan_nto2n.sv
// ============================================================================
// tb_dec_scan_nto2n : bench for dec_scan_nto2n with SCAN_DIV=4 and SCAN_DIV=1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dec_scan_nto2n;

  logic       clk = 1'b0;
  logic       r_rst_n = 1'b0;
  logic       r_en = 1'b0;
  logic       r_mode = 1'b0;
  logic [2:0] r_in = 3'd0;

  logic [7:0] w_out4, w_out1;
  logic [2:0] w_idx4, w_idx1;
  logic       w_valid4, w_valid1, w_wrap4, w_wrap1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dec_scan_nto2n #(.IN_W(3), .SCAN_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(r_rst_n), .en(r_en), .mode(r_mode), .in(r_in),
    .out(w_out4), .idx(w_idx4), .valid(w_valid4), .wrap(w_wrap4)
  );

  dec_scan_nto2n #(.IN_W(3), .SCAN_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(r_rst_n), .en(r_en), .mode(r_mode), .in(r_in),
    .out(w_out1), .idx(w_idx1), .valid(w_valid1), .wrap(w_wrap1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: scan position is simply cycles elapsed since scan entry.
  int         m_k    [2];
  bit         m_scan [2];
  int         m_div  [2] = '{4, 1};
  logic [7:0] m_out  [2];
  logic [2:0] m_idx  [2];
  logic       m_valid[2];
  logic       m_wrap [2];

  task automatic step(input logic rn, input logic e, input logic m, input logic [2:0] ix);
    logic [7:0] o;
    logic [2:0] id;
    logic       v, w;
    r_rst_n = rn; r_en = e; r_mode = m; r_in = ix;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rn || !e) begin
        m_out[i] = 8'h00; m_idx[i] = 3'd0; m_valid[i] = 1'b0; m_wrap[i] = 1'b0;
        m_scan[i] = 1'b0;
      end else if (!m) begin
        m_out[i] = 8'h01 << ix; m_idx[i] = ix; m_valid[i] = 1'b1; m_wrap[i] = 1'b0;
        m_scan[i] = 1'b0;
      end else begin
        if (!m_scan[i]) begin
          m_scan[i] = 1'b1;
          m_k[i] = 0;
        end else begin
          m_k[i]++;
        end
        m_idx[i]   = 3'((m_k[i] / m_div[i]) % 8);
        m_out[i]   = 8'h01 << m_idx[i];
        m_valid[i] = 1'b1;
`ifdef DEC_SCAN_WRAP_EN
        m_wrap[i]  = (m_k[i] > 0) && (m_k[i] % (8 * m_div[i]) == 0);
`else
        m_wrap[i]  = 1'b0;
`endif
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      o  = (i == 0) ? w_out4   : w_out1;
      id = (i == 0) ? w_idx4   : w_idx1;
      v  = (i == 0) ? w_valid4 : w_valid1;
      w  = (i == 0) ? w_wrap4  : w_wrap1;
      chk($sformatf("out_div%0d", m_div[i]), 32'(o), 32'(m_out[i]));
      chk($sformatf("idx_div%0d", m_div[i]), 32'(id), 32'(m_idx[i]));
      chk($sformatf("valid_div%0d", m_div[i]), 32'(v), 32'(m_valid[i]));
      chk($sformatf("wrap_div%0d", m_div[i]), 32'(w), 32'(m_wrap[i]));
      chk($sformatf("onehot_div%0d", m_div[i]), 32'($countones(o) <= 1), 32'd1);
    end
  endtask

  initial begin
    logic [3:0] t2_vec [6] = '{4'b0000, 4'b1000, 4'b1010, 4'b1100, 4'b1001, 4'b1111};
    logic [7:0] t2_exp [6] = '{8'h00, 8'h01, 8'h04, 8'h10, 8'h02, 8'h80};
    logic       mode_q;

    // T1: reset dominates en/mode
    step(1'b0, 1'b1, 1'b1, 3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0);
    chk("t1_out", 32'(w_out4), 32'h0);

    // T2: direct decode, with literal expectations alongside the model
    for (int i = 0; i < 6; i++) begin
      step(1'b1, t2_vec[i][3], 1'b0, t2_vec[i][2:0]);
      chk("t2_out", 32'(w_out4), 32'(t2_exp[i]));
    end

    // T3: full sweep from IDLE plus a few cycles past the wrap
    step(1'b1, 1'b0, 1'b1, 3'd0);
    for (int c = 1; c <= 36; c++) begin
      step(1'b1, 1'b1, 1'b1, 3'd0);
      if (c == 32) chk("t3_top", 32'(w_out4), 32'h80);
      if (c == 33) chk("t3_wrap_out", 32'(w_out4), 32'h01);
    end

    // T4: drop en mid-scan, then re-enable
    step(1'b1, 1'b0, 1'b1, 3'd0);
    for (int c = 1; c <= 10; c++) step(1'b1, 1'b1, 1'b1, 3'd0);
    chk("t4_pre", 32'(w_out4), 32'h04);
    step(1'b1, 1'b0, 1'b1, 3'd0);
    chk("t4_off", 32'(w_out4), 32'h00);
    for (int c = 1; c <= 5; c++) step(1'b1, 1'b1, 1'b1, 3'd0);

    // T5: SCAN -> DIRECT at idx 5, back to SCAN, then reset at idx 3
    step(1'b1, 1'b0, 1'b1, 3'd0);
    for (int c = 1; c <= 21; c++) step(1'b1, 1'b1, 1'b1, 3'd0);
    chk("t5_idx5", 32'(w_idx4), 32'd5);
    step(1'b1, 1'b1, 1'b0, 3'd2);
    chk("t5_direct", 32'(w_out4), 32'h04);
    for (int c = 1; c <= 13; c++) step(1'b1, 1'b1, 1'b1, 3'd0);
    chk("t5_idx3", 32'(w_idx4), 32'd3);
    step(1'b0, 1'b1, 1'b1, 3'd0);
    chk("t5_rst", 32'(w_out4), 32'h00);

    // Random traffic with sticky mode so long scans occur
    mode_q = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) mode_q = ~mode_q;
      step(($urandom_range(39) != 0), ($urandom_range(11) != 0), mode_q,
           3'($urandom_range(7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
